// File: rtl/response_compactor.sv
// response_compactor: serial-input signature register (LFSR compactor) that
// folds a window of window_len response bits into a SIG_W-bit signature.
// A window is requested with start in IDLE, runs for window_len clocks in
// RUN, and is closed by a single-cycle DONE state that pulses done.
// Optional feature macro: ONES_COUNT_EN adds a count of din==1 samples on
// ones_cnt; without it ones_cnt is tied to zero and no counter is built.
//
// state | meaning
// IDLE  | waiting for start; signature/ones_cnt hold the last result
// RUN   | one din sample folded into the signature per clock
// DONE  | one-cycle completion marker (done=1), then back to IDLE
module response_compactor #(
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             din,
  input  logic             start,
  input  logic [7:0]       window_len,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [7:0]       ones_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       remaining_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_next;
  logic             fb;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

  // Next-state decode; remaining==1 means this edge takes the last sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (window_len == 8'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (remaining_q == 8'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Feedback step of the signature register for the current din sample.
  always_comb begin
    fb       = sig_q[SIG_W-1] ^ din;
    sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : {SIG_W{1'b0}});
  end

  // Signature and remaining-sample counter; window_len is captured only on
  // the accepting edge so later changes cannot disturb the active window.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      sig_q       <= SEED;
      remaining_q <= 8'd0;
    end else if (accept) begin
      sig_q       <= SEED;
      remaining_q <= window_len;
    end else if (state_q == RUN) begin
      sig_q       <= sig_next;
      remaining_q <= remaining_q - 8'd1;
    end
  end

`ifdef ONES_COUNT_EN
  logic [7:0] ones_q;

  // Count of din==1 samples in the current/last window.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      ones_q <= 8'd0;
    end else if (accept) begin
      ones_q <= 8'd0;
    end else if ((state_q == RUN) && din) begin
      ones_q <= ones_q + 8'd1;
    end
  end

  assign ones_cnt = ones_q;
`else
  assign ones_cnt = 8'd0;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign signature = sig_q;

endmodule
